// File: rtl/spi_mcu_pkt_slave_if.sv
// Signal bundle between the MCU-facing SPI slave and the router core.
// The slave modport is the block itself; master is the MCU pins plus core side.
interface spi_mcu_pkt_slave_if;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_first;
  logic       rx_last;
  logic       rx_type;
  logic [5:0] rx_len;
  logic       rx_abort;
  logic       rx_overrun;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_underrun;

  modport slave (
    input  sclk, mosi, ss, tx_data, tx_load,
    output miso, rx_byte, rx_valid, rx_first, rx_last, rx_type, rx_len,
           rx_abort, rx_overrun, tx_ready, tx_underrun
  );

  modport master (
    output sclk, mosi, ss, tx_data, tx_load,
    input  miso, rx_byte, rx_valid, rx_first, rx_last, rx_type, rx_len,
           rx_abort, rx_overrun, tx_ready, tx_underrun
  );
endinterface

// File: rtl/spi_mcu_pkt_slave.sv
// Oversampling SPI mode-0 slave: deframes interest/data packets from the MCU
// into a byte stream and returns core-supplied bytes full-duplex on miso.
module spi_mcu_pkt_slave #(
  parameter int PREFIX_BYTES = 8,
  parameter int DATA_BYTES   = 256,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_mcu_pkt_slave_if.slave  bus
);
  localparam int MAX_BYTES = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] PREFIX_CNT = CNT_W'(PREFIX_BYTES);
  localparam logic [CNT_W-1:0] DATA_CNT   = CNT_W'(DATA_BYTES);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  logic [SYNC_N-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic              sclk_prev_q, ss_prev_q;
  logic              sclk_s, mosi_s, ss_s;
  logic              sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
  logic [7:0]        rx_in_s;
  logic              byte_done_s, load_evt_s;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d, target_q, target_d;
  logic [7:0]        rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d, rx_first_q, rx_first_d, rx_last_q, rx_last_d;
  logic              rx_type_q, rx_type_d, rx_abort_q, rx_abort_d, rx_overrun_q, rx_overrun_d;
  logic [5:0]        rx_len_q, rx_len_d;
  logic [7:0]        hold_q, hold_d, tx_shift_q, tx_shift_d;
  logic              tx_ready_q, tx_ready_d, tx_underrun_q, tx_underrun_d, miso_q, miso_d;

  // ss synchronisers reset low so a select already held low through reset is
  // never mistaken for a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_N{1'b0}};
      mosi_sync_q <= {SYNC_N{1'b0}};
      ss_sync_q   <= {SYNC_N{1'b0}};
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_N-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], bus.mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_N-2:0], bus.ss};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_N-1];
  assign mosi_s      = mosi_sync_q[SYNC_N-1];
  assign ss_s        = ss_sync_q[SYNC_N-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign ss_rise_s   = ss_s & ~ss_prev_q;
  assign ss_fall_s   = ~ss_s & ss_prev_q;
  assign rx_in_s     = {rx_shift_q[6:0], mosi_s};

  // Frame state machine and receive path.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    target_d     = target_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    rx_type_d    = rx_type_q;
    rx_len_d     = rx_len_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    rx_last_d    = 1'b0;
    rx_abort_d   = 1'b0;
    rx_overrun_d = 1'b0;
    byte_done_s  = 1'b0;
    if (ss_rise_s) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = CNT_ZERO;
      rx_abort_d = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    end else if (state_q == ST_IDLE) begin
      if (ss_fall_s) begin
        state_d    = ST_HEADER;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = CNT_ZERO;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (sclk_rise_s) begin
      rx_shift_d = rx_in_s;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_s = 1'b1;
        case (state_q)
          ST_HEADER: begin
            rx_valid_d = 1'b1;
            rx_first_d = 1'b1;
            rx_byte_d  = rx_in_s;
            rx_type_d  = rx_in_s[6];
            rx_len_d   = rx_in_s[5:0];
            target_d   = rx_in_s[6] ? PREFIX_CNT : DATA_CNT;
            byte_cnt_d = CNT_ZERO;
            state_d    = ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_in_s;
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            if ((byte_cnt_q + CNT_ONE) == target_q) begin
              rx_last_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              rx_last_d = 1'b0;
            end
          end
          ST_DONE:  rx_overrun_d = 1'b1;
          default:  state_d = ST_IDLE;
        endcase
      end else begin
        byte_done_s = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign load_evt_s = (ss_fall_s && (state_q == ST_IDLE) && !ss_rise_s) || byte_done_s;

  // Transmit path. The first sclk fall after a load (bit counter back at 0)
  // must not shift, so the freshly loaded MSB is what the next rise samples.
  always_comb begin
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    tx_shift_d    = tx_shift_q;
    tx_underrun_d = 1'b0;
    if (load_evt_s) begin
      tx_shift_d    = tx_ready_q ? 8'h00 : hold_q;
      tx_underrun_d = tx_ready_q;
      tx_ready_d    = 1'b1;
    end else if (sclk_fall_s && (state_q != ST_IDLE) && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
    end
    if (bus.tx_load && (tx_ready_q || load_evt_s)) begin
      hold_d     = bus.tx_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end
    miso_d = ss_s ? 1'b0 : tx_shift_d[7];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= CNT_ZERO;
      target_q      <= CNT_ZERO;
      rx_shift_q    <= 8'h00;
      rx_byte_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      rx_last_q     <= 1'b0;
      rx_type_q     <= 1'b0;
      rx_len_q      <= 6'd0;
      rx_abort_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      hold_q        <= 8'h00;
      tx_ready_q    <= 1'b1;
      tx_shift_q    <= 8'h00;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      target_q      <= target_d;
      rx_shift_q    <= rx_shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      rx_first_q    <= rx_first_d;
      rx_last_q     <= rx_last_d;
      rx_type_q     <= rx_type_d;
      rx_len_q      <= rx_len_d;
      rx_abort_q    <= rx_abort_d;
      rx_overrun_q  <= rx_overrun_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      tx_shift_q    <= tx_shift_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_first    = rx_first_q;
  assign bus.rx_last     = rx_last_q;
  assign bus.rx_type     = rx_type_q;
  assign bus.rx_len      = rx_len_q;
  assign bus.rx_abort    = rx_abort_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_underrun = tx_underrun_q;
endmodule

// File: tb/tb_spi_mcu_pkt_slave.sv
// Randomised bench for spi_mcu_pkt_slave: acts as the MCU master and the core,
// predicting frames, strobes and miso bytes from the packet rules.
module tb_spi_mcu_pkt_slave;
  localparam int PREFIX_BYTES = 8;
  localparam int DATA_BYTES   = 256;
  localparam int SYNC_STAGES  = 2;
  localparam int HALF         = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mcu_pkt_slave_if bus ();

  spi_mcu_pkt_slave #(
    .PREFIX_BYTES (PREFIX_BYTES),
    .DATA_BYTES   (DATA_BYTES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_cnt = 0;
  int fail_cnt   = 0;

  logic [7:0] mo_bytes [0:299];
  logic [7:0] tx_vals  [0:300];
  bit         tx_give  [0:300];
  bit         mh_full;
  logic [7:0] mh_val;
  int         exp_udr;

  logic [9:0] mon_q [$];
  int         mon_abort, mon_ovr, mon_udr;
  logic       mon_type;
  logic [5:0] mon_len;

  // Core-side observer: records every strobe the block emits.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      mon_q.push_back({bus.rx_first, bus.rx_last, bus.rx_byte});
      if (bus.rx_first) begin
        mon_type = bus.rx_type;
        mon_len  = bus.rx_len;
      end
    end
    if (bus.rx_abort)    mon_abort++;
    if (bus.rx_overrun)  mon_ovr++;
    if (bus.tx_underrun) mon_udr++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Core offers the byte for a slot whenever the holding register is free.
  task automatic tx_offer(input int slot);
    check_val("tx_ready", 32'(bus.tx_ready), 32'(!mh_full));
    if (tx_give[slot] && !mh_full) begin
      bus.tx_data = tx_vals[slot];
      bus.tx_load = 1'b1;
      wait_clks(1);
      bus.tx_load = 1'b0;
      mh_full = 1'b1;
      mh_val  = tx_vals[slot];
    end
  endtask

  task automatic mdl_load(output logic [7:0] sent);
    if (mh_full) begin
      sent = mh_val;
    end else begin
      sent = 8'h00;
      exp_udr++;
    end
    mh_full = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] val, input int nb, input bit offer,
                           input int slot, output logic [7:0] seen);
    seen = 8'h00;
    for (int i = 0; i < nb; i++) begin
      bus.mosi = val[7-i];
      wait_clks(HALF);
      bus.sclk = 1'b1;
      seen = {seen[6:0], bus.miso};
      if (offer && i == 3) tx_offer(slot);
      wait_clks(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  // One ss-framed transfer: n_full whole bytes then n_part extra bits.
  task automatic run_frame(input int n_full, input int n_part);
    logic [7:0] seen, sent;
    logic [7:0] exp_tx [$];
    logic [9:0] e;
    int target, n_pay, n_bytes, exp_n;
    mon_q.delete();
    mon_abort = 0; mon_ovr = 0; mon_udr = 0; exp_udr = 0;
    target = mo_bytes[0][6] ? PREFIX_BYTES : DATA_BYTES;
    tx_offer(0);
    wait_clks(2);
    bus.ss = 1'b0;
    mdl_load(sent);
    exp_tx.push_back(sent);
    wait_clks(6);
    n_bytes = n_full + ((n_part > 0) ? 1 : 0);
    for (int b = 0; b < n_bytes; b++) begin
      if (b < n_full) begin
        send_bits(mo_bytes[b], 8, 1'b1, b + 1, seen);
        check_val("miso_byte", 32'(seen), 32'(exp_tx[b]));
        mdl_load(sent);
        exp_tx.push_back(sent);
      end else begin
        send_bits(mo_bytes[b], n_part, 1'b1, b + 1, seen);
      end
    end
    wait_clks(6);
    bus.ss = 1'b1;
    wait_clks(8);
    n_pay = (n_full > 0) ? n_full - 1 : 0;
    exp_n = (n_full > 0) ? 1 + ((n_pay < target) ? n_pay : target) : 0;
    check_val("rx_count", mon_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < mon_q.size(); i++) begin
      e = {(i == 0), (i == target), mo_bytes[i]};
      check_val("rx_entry", 32'(mon_q[i]), 32'(e));
    end
    check_val("rx_abort_cnt", mon_abort, (n_full < target + 1) ? 1 : 0);
    check_val("rx_overrun_cnt", mon_ovr, (n_pay > target) ? n_pay - target : 0);
    check_val("tx_underrun_cnt", mon_udr, exp_udr);
    if (n_full > 0) begin
      check_val("hdr_type", 32'(mon_type), 32'(mo_bytes[0][6]));
      check_val("hdr_len", 32'(mon_len), 32'(mo_bytes[0][5:0]));
      check_val("type_hold", 32'(bus.rx_type), 32'(mo_bytes[0][6]));
      check_val("len_hold", 32'(bus.rx_len), 32'(mo_bytes[0][5:0]));
    end
    check_val("miso_idle", 32'(bus.miso), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("rst_rx_byte", 32'(bus.rx_byte), 32'd0);
    check_val("rst_rx_first", 32'(bus.rx_first), 32'd0);
    check_val("rst_rx_last", 32'(bus.rx_last), 32'd0);
    check_val("rst_rx_type", 32'(bus.rx_type), 32'd0);
    check_val("rst_rx_len", 32'(bus.rx_len), 32'd0);
    check_val("rst_rx_abort", 32'(bus.rx_abort), 32'd0);
    check_val("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    check_val("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    check_val("rst_miso", 32'(bus.miso), 32'd0);
  endtask

  task automatic rand_tx(input int n);
    for (int i = 0; i <= n; i++) begin
      tx_give[i] = bit'($urandom_range(0, 1));
      tx_vals[i] = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] seen;
    int nf, np;
    bus.sclk = 1'b0; bus.mosi = 1'b0; bus.ss = 1'b1;
    bus.tx_data = 8'h00; bus.tx_load = 1'b0;
    mh_full = 1'b0; mh_val = 8'h00;
    rst = 1'b1;
    wait_clks(4);
    check_reset_outputs();
    rst = 1'b0;
    wait_clks(6);

    // Interest frame 0x48 + 0x01..0x08; core supplies 0xA5, 0x3C then nothing.
    mo_bytes[0] = 8'h48;
    for (int i = 1; i <= 8; i++) mo_bytes[i] = 8'(i);
    for (int i = 0; i <= 300; i++) begin tx_give[i] = 1'b0; tx_vals[i] = 8'h00; end
    tx_give[0] = 1'b1; tx_vals[0] = 8'hA5;
    tx_give[1] = 1'b1; tx_vals[1] = 8'h3C;
    run_frame(9, 0);

    // Data frame with 256 payload bytes.
    mo_bytes[0] = 8'h00;
    for (int i = 1; i <= 256; i++) mo_bytes[i] = 8'(i - 1);
    rand_tx(258);
    run_frame(257, 0);

    // Abort after 3 payload bytes and 5 bits, then a clean interest frame.
    mo_bytes[0] = 8'h48;
    for (int i = 1; i <= 10; i++) mo_bytes[i] = 8'($urandom);
    rand_tx(6);
    run_frame(4, 5);
    rand_tx(10);
    run_frame(9, 0);

    // Two bytes beyond the end of an interest frame.
    mo_bytes[0] = 8'h45;
    rand_tx(12);
    run_frame(11, 0);

    // Reset in the middle of the payload with a byte waiting in the holding register.
    mon_abort = 0;
    bus.ss = 1'b0;
    wait_clks(6);
    send_bits(8'h48, 8, 1'b0, 0, seen);
    send_bits(8'h11, 8, 1'b0, 0, seen);
    bus.tx_data = 8'h77; bus.tx_load = 1'b1;
    wait_clks(1);
    bus.tx_load = 1'b0;
    check_val("ready_before_rst", 32'(bus.tx_ready), 32'd0);
    send_bits(8'h22, 3, 1'b0, 0, seen);
    rst = 1'b1;
    wait_clks(1);
    check_reset_outputs();
    rst = 1'b0;
    mh_full = 1'b0;
    wait_clks(4);
    bus.ss = 1'b1;
    wait_clks(8);
    check_val("rst_no_abort", mon_abort, 0);

    // Random frames, mostly interest; data frames are cut short.
    for (int f = 0; f < 16; f++) begin
      mo_bytes[0] = 8'($urandom);
      mo_bytes[0][6] = ($urandom_range(0, 7) != 0);
      for (int i = 1; i <= 25; i++) mo_bytes[i] = 8'($urandom);
      if (mo_bytes[0][6]) begin
        nf = $urandom_range(0, 11);
        np = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      end else begin
        nf = $urandom_range(1, 20);
        np = $urandom_range(0, 7);
      end
      rand_tx(nf + 1);
      run_frame(nf, np);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule
